palindrome_generator: RTL

Sequential source of 16-bit palindromes, the generating counterpart of the team's combinational palindrome checker. After a `start` pulse it streams, in strictly ascending order, every 16-bit value the checker accepts for the selected mode. Output uses a valid/ready handshake. Benches use it to drive checkers, and datapaths use it as a palindrome test-pattern source.

---
 rtl/palindrome_pkg.sv | 28 ++
 rtl/palindrome_value.sv | 36 +++
 rtl/palindrome_generator.sv | 117 +++++++++++
 3 files changed

// File: rtl/palindrome_pkg.sv
// Shared constants and helpers for the palindrome generator.
// Mode codes, stream limits and decimal digit weights.
package palindrome_pkg;

  localparam logic PAL_MODE_BIN = 1'b0;
  localparam logic PAL_MODE_DEC = 1'b1;

  localparam logic [15:0] PAL_BIN_LAST = 16'hFFFF;
  localparam logic [15:0] PAL_DEC_LAST = 16'd65456;

  localparam int PAL_BIN_LEN = 256;
  localparam int PAL_DEC_LEN = 655;

  localparam logic [16:0] PAL_W_A = 17'd10001;
  localparam logic [16:0] PAL_W_B = 17'd1010;
  localparam logic [16:0] PAL_W_C = 17'd100;

  function automatic logic [7:0] bit_rev8(
    input logic [7:0] x
  );
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = x[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/palindrome_value.sv
// Maps the generator's index state to a 16-bit palindrome.
// Also flags the final value of each mode's stream.
module palindrome_value
  import palindrome_pkg::*;
(
  input  logic        mode,
  input  logic [7:0]  h,
  input  logic [3:0]  a,
  input  logic [3:0]  b,
  input  logic [3:0]  c,
  output logic [15:0] value,
  output logic        last
);

  logic [16:0] sum;
  logic        in_range;
  logic [15:0] dec_value;

  always_comb begin
    sum = 17'(a) * PAL_W_A
        + 17'(b) * PAL_W_B
        + 17'(c) * PAL_W_C;
    in_range = ~sum[16];
    // Clamp guards against an out-of-range index ever reaching the bus.
    dec_value = in_range ? sum[15:0]
                         : PAL_DEC_LAST;
    if (mode == PAL_MODE_DEC) begin
      value = dec_value;
      last  = (dec_value == PAL_DEC_LAST);
    end else begin
      value = {h, bit_rev8(h)};
      last  = (h == 8'hFF);
    end
  end

endmodule

// File: rtl/palindrome_generator.sv
// Streams ascending 16-bit palindromes over valid/ready.
// Binary bit-mirror or 5-digit decimal, chosen at start.
module palindrome_generator
  import palindrome_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        done,
  output logic [9:0]  count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic        mode_q;
  logic        last_q;
  logic [7:0]  h, h_nx;
  logic [3:0]  a, b, c;
  logic [3:0]  a_nx, b_nx, c_nx;
  logic [15:0] nx_value;
  logic        nx_last;
  logic        xfer;

  assign busy      = (state == RUN);
  assign out_valid = (state == RUN);
  assign xfer      = out_valid & out_ready;

  always_comb begin
    h_nx = h;
    a_nx = a;
    b_nx = b;
    c_nx = c;
    if (mode_q == PAL_MODE_DEC) begin
      if (c == 4'd9) begin
        c_nx = 4'd0;
        if (b == 4'd9) begin
          b_nx = 4'd0;
          a_nx = a + 4'd1;
        end else begin
          b_nx = b + 4'd1;
        end
      end else begin
        c_nx = c + 4'd1;
      end
    end else begin
      h_nx = h + 8'd1;
    end
  end

  // Evaluated on the next index so out_data can be registered.
  palindrome_value u_value (
    .mode  (mode_q),
    .h     (h_nx),
    .a     (a_nx),
    .b     (b_nx),
    .c     (c_nx),
    .value (nx_value),
    .last  (nx_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= PAL_MODE_BIN;
      last_q   <= 1'b0;
      h        <= '0;
      a        <= '0;
      b        <= '0;
      c        <= '0;
      out_data <= '0;
      count    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            mode_q   <= mode;
            last_q   <= 1'b0;
            h        <= '0;
            a        <= '0;
            b        <= '0;
            c        <= '0;
            out_data <= '0;
            count    <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            count <= count + 10'd1;
            if (last_q) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              h        <= h_nx;
              a        <= a_nx;
              b        <= b_nx;
              c        <= c_nx;
              out_data <= nx_value;
              last_q   <= nx_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
